// File: rtl/cnn_pkg.sv
// Shared types and constants for the classifier output path.
//   tx_state_t      : transmitter FSM states
//   rx_state_t      : loopback receiver FSM states
//   BAUD_DIV_115200 : clocks per bit at 50 MHz / 115200 baud
//   frame_word()    : builds the 8N1 frame {stop, data, start}
package cnn_pkg;

  localparam int unsigned BAUD_DIV_115200 = 434;
  localparam int unsigned BAUD_CNT_W      = 12;
  localparam int unsigned BIT_CNT_W       = 4;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned FRAME_W         = DATA_W + 2;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Stop bit in the MSB, start bit in the LSB so the frame shifts out from bit 0.
  function automatic logic [FRAME_W-1:0] frame_word(input logic [DATA_W-1:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, companion to uart_tx; used as a loopback checker on bring-up.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   rx            : serial input (idle 1)
//   rx_data       : last received byte
//   rx_rdy        : one-cycle pulse when rx_data/rx_frame_err are updated
//   rx_frame_err  : stop bit of the last frame sampled as 0
module uart_rx
  import cnn_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_rdy,
  output logic              rx_frame_err
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(BAUD_DIV / 2 - 1);

  rx_state_t               state_q, state_d;
  logic                    rx_meta_q, rx_sync_q;
  logic [BAUD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    rdy_q, rdy_d;
  logic                    ferr_q, ferr_d;

  // Two-flop synchronizer; idles high so reset does not fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  // Start edge, re-check at mid start bit, then sample every bit period at mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + BAUD_CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + BAUD_CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          data_d  = shift_q;
          ferr_d  = ~rx_sync_q;
          rdy_d   = 1'b1;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + BAUD_CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_rdy       = rdy_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter carrying the classifier result off-chip.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   trmt     : transmit request, sampled only in IDLE
//   tx_data  : byte to send, captured on the accepting edge
//   TX       : serial line, idle/reset level 1, driven straight from a flop
//   tx_done  : sticky completion flag, cleared when the next request is accepted
module uart_tx
  import cnn_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_done
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(FRAME_W - 1);

  tx_state_t              state_q, state_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [BAUD_CNT_W-1:0]  baud_q, baud_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic                   done_q, done_d;

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        shift_d = '1;
        baud_d  = '0;
        bit_d   = '0;
        if (trmt) begin
          shift_d = frame_word(tx_data);
          done_d  = 1'b0;
          state_d = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          bit_d   = bit_q + BIT_CNT_W'(1);
          // Stop bit has run its full period: frame complete.
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_CNT_W'(1);
        end
      end
    endcase
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;

endmodule
